// File: rtl/call_stack_pkg.sv
// Shared CPU definitions for the return-address stack: address width,
// default depth, control opcodes and the stack error encoding.
package call_stack_pkg;

    localparam int unsigned CPU_ADDR_W = 19;
    localparam int unsigned CS_DEPTH   = 8;

    // Control opcodes that the decoder turns into stack strobes
    typedef enum logic [1:0] {
        OP_CALL = 2'd0,
        OP_RET  = 2'd1,
        OP_PUSH = 2'd2,
        OP_POP  = 2'd3
    } stack_op_e;

    // Error encoding as {underflow, overflow}
    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_UNDERFLOW = 2'd2,
        ERR_BOTH      = 2'd3
    } stack_err_e;

    // Pack the two sticky flags into the error encoding
    function automatic stack_err_e encode_err(input logic ovf, input logic unf);
        return stack_err_e'({unf, ovf});
    endfunction

endpackage

// File: rtl/call_stack_regfile.sv
// DEPTH x ADDR_W storage for the return-address stack: one synchronous
// write port, one asynchronous read port. Contents are not reset.
module call_stack_regfile
    import call_stack_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned DEPTH  = CS_DEPTH,
    localparam int unsigned IDX_W = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_data
);

    logic [ADDR_W-1:0] mem [DEPTH];

    // Single write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack for the 19-bit CPU. Push on call, pop on
// explicit pop or ret; ret additionally pulses ret_valid to redirect fetch.
// Hazard stalls freeze it. Optional macro CALL_STACK_WRAP_EN makes a push
// while full overwrite the oldest entry instead of being dropped.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned DEPTH  = CS_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1,
    localparam int unsigned IDX_W = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              ret,
    input  logic              hazard,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              clear_err,
    output logic [ADDR_W-1:0] top_addr,
    output logic [ADDR_W-1:0] ret_addr,
    output logic              ret_valid,
    output logic [PTR_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    logic [IDX_W-1:0]  sp;
    logic [IDX_W-1:0]  sp_next;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  count_next;
    logic [ADDR_W-1:0] rd_data;
    logic [ADDR_W-1:0] ret_addr_next;
    logic              ret_valid_next;
    logic              overflow_next;
    logic              underflow_next;
    logic              ovf_evt;
    logic              unf_evt;
    logic              wr_en;
    logic              do_push;
    logic              do_pop;
    logic              do_ret;

    assign do_push = push & ~hazard;
    assign do_pop  = (pop | ret) & ~hazard;
    assign do_ret  = ret & ~hazard;

    assign full    = (count == PTR_W'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = sp - IDX_W'(1);

    call_stack_regfile #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (push_addr),
        .rd_idx  (top_idx),
        .rd_data (rd_data)
    );

    // Stale array contents must never be visible while empty
    assign top_addr = empty ? '0 : rd_data;

    // Next-state for pointer, occupancy, popped address and error events
    always_comb begin
        sp_next        = sp;
        count_next     = count;
        wr_en          = 1'b0;
        wr_idx         = sp;
        ret_addr_next  = ret_addr;
        ret_valid_next = 1'b0;
        ovf_evt        = 1'b0;
        unf_evt        = 1'b0;

        if (do_push && do_pop) begin
            if (empty) begin
                // Nothing to pop: behaves as a plain push
                wr_en      = 1'b1;
                wr_idx     = sp;
                sp_next    = sp + IDX_W'(1);
                count_next = count + PTR_W'(1);
                unf_evt    = 1'b1;
            end else begin
                // Replace the top entry, hand back the old one
                wr_en          = 1'b1;
                wr_idx         = top_idx;
                ret_addr_next  = rd_data;
                ret_valid_next = do_ret;
            end
        end else if (do_push) begin
            if (!full) begin
                wr_en      = 1'b1;
                wr_idx     = sp;
                sp_next    = sp + IDX_W'(1);
                count_next = count + PTR_W'(1);
            end else begin
                ovf_evt = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                // Circular: sp slot holds the oldest entry when full
                wr_en   = 1'b1;
                wr_idx  = sp;
                sp_next = sp + IDX_W'(1);
`endif
            end
        end else if (do_pop) begin
            if (!empty) begin
                ret_addr_next  = rd_data;
                ret_valid_next = do_ret;
                sp_next        = top_idx;
                count_next     = count - PTR_W'(1);
            end else begin
                unf_evt = 1'b1;
            end
        end

        // A new error in the same cycle wins over clear_err
        overflow_next  = ovf_evt | (overflow & ~clear_err);
        underflow_next = unf_evt | (underflow & ~clear_err);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp        <= '0;
            count     <= '0;
            ret_addr  <= '0;
            ret_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_next;
            count     <= count_next;
            ret_addr  <= ret_addr_next;
            ret_valid <= ret_valid_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack with a scoreboard queue of expected
// ret_addr values, consumed when ret_valid pulses.
module tb_call_stack;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned PTR_W  = 4;

`ifdef CALL_STACK_WRAP_EN
    localparam logic [18:0] LAST_POP = 19'h01001;
`else
    localparam logic [18:0] LAST_POP = 19'h01000;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              ret = 1'b0;
    logic              hazard = 1'b0;
    logic [ADDR_W-1:0] push_addr = '0;
    logic              clear_err = 1'b0;
    logic [ADDR_W-1:0] top_addr;
    logic [ADDR_W-1:0] ret_addr;
    logic              ret_valid;
    logic [PTR_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    int passed = 0;
    int total  = 0;
    logic [18:0] exp_q[$];

    call_stack dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .ret       (ret),
        .hazard    (hazard),
        .push_addr (push_addr),
        .clear_err (clear_err),
        .top_addr  (top_addr),
        .ret_addr  (ret_addr),
        .ret_valid (ret_valid),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock, then compare the ret pulse against the scoreboard
    task automatic cycle();
        logic [18:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ret_valid", 32'(ret_valid), 32'd1);
            check("ret_addr", 32'(ret_addr), 32'(e));
        end else begin
            check("ret_valid_idle", 32'(ret_valid), 32'd0);
        end
    endtask

    task automatic push_one(input logic [18:0] a);
        push = 1'b1;
        push_addr = a;
        cycle();
        push = 1'b0;
    endtask

    task automatic ret_one(input logic [18:0] e);
        ret = 1'b1;
        exp_q.push_back(e);
        cycle();
        ret = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_top", 32'(top_addr), 32'd0);
        check("rst_ret_valid", 32'(ret_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        cycle();
        rst = 1'b0;
        cycle();

        // 1: push three, ret three
        push_one(19'h00010);
        push_one(19'h00020);
        push_one(19'h00030);
        check("t1_count", 32'(count), 32'd3);
        check("t1_top", 32'(top_addr), 32'h30);
        ret_one(19'h00030);
        ret_one(19'h00020);
        ret_one(19'h00010);
        cycle();
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_top_empty", 32'(top_addr), 32'd0);

        // 2: fill, then push while full
        for (int i = 0; i < 8; i++) push_one(19'h01000 + 19'(i));
        check("t2_full", 32'(full), 32'd1);
        check("t2_count8", 32'(count), 32'd8);
        check("t2_ovf_pre", 32'(overflow), 32'd0);
        push_one(19'h7FFFF);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_full_post", 32'(full), 32'd1);
        check("t2_count_post", 32'(count), 32'd8);
`ifdef CALL_STACK_WRAP_EN
        check("t2_top", 32'(top_addr), 32'h7FFFF);
        ret_one(19'h7FFFF);
        for (int i = 7; i >= 1; i--) ret_one(19'h01000 + 19'(i));
`else
        check("t2_top", 32'(top_addr), 32'h01007);
        for (int i = 7; i >= 0; i--) ret_one(19'h01000 + 19'(i));
`endif
        check("t2_empty", 32'(empty), 32'd1);
        clear_err = 1'b1;
        cycle();
        clear_err = 1'b0;
        check("t2_ovf_clr", 32'(overflow), 32'd0);

        // 3: ret on empty, error priority over clear
        ret = 1'b1;
        cycle();
        ret = 1'b0;
        check("t3_unf", 32'(underflow), 32'd1);
        check("t3_ret_held", 32'(ret_addr), 32'(LAST_POP));
        check("t3_count", 32'(count), 32'd0);
        ret = 1'b1;
        clear_err = 1'b1;
        cycle();
        ret = 1'b0;
        check("t3_unf_prio", 32'(underflow), 32'd1);
        cycle();
        clear_err = 1'b0;
        check("t3_unf_clr", 32'(underflow), 32'd0);

        // 4: push + ret same cycle replaces top; then pop without pulse
        push_one(19'h00100);
        push = 1'b1;
        push_addr = 19'h00200;
        ret = 1'b1;
        exp_q.push_back(19'h00100);
        cycle();
        push = 1'b0;
        ret = 1'b0;
        check("t4_count", 32'(count), 32'd1);
        check("t4_top", 32'(top_addr), 32'h200);
        pop = 1'b1;
        cycle();
        pop = 1'b0;
        check("t4_pop_addr", 32'(ret_addr), 32'h200);
        check("t4_pop_empty", 32'(empty), 32'd1);
        check("t4_unf", 32'(underflow), 32'd0);

        // push + ret on empty acts as push and flags underflow
        push = 1'b1;
        push_addr = 19'h00055;
        ret = 1'b1;
        cycle();
        push = 1'b0;
        ret = 1'b0;
        check("pe_count", 32'(count), 32'd1);
        check("pe_top", 32'(top_addr), 32'h55);
        check("pe_unf", 32'(underflow), 32'd1);
        clear_err = 1'b1;
        cycle();
        clear_err = 1'b0;

        // 5: hazard blocks all strobes
        hazard = 1'b1;
        push = 1'b1;
        ret = 1'b1;
        push_addr = 19'h00400;
        cycle();
        hazard = 1'b0;
        push = 1'b0;
        ret = 1'b0;
        check("t5_count", 32'(count), 32'd1);
        check("t5_top", 32'(top_addr), 32'h55);
        check("t5_unf", 32'(underflow), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);

        // 6: async reset mid-operation with a pulse in flight
        for (int i = 0; i < 5; i++) push_one(19'h00600 + 19'(i));
        ret_one(19'h00604);
        check("t6_count5", 32'(count), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("t6_count", 32'(count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_top", 32'(top_addr), 32'd0);
        check("t6_ret_valid", 32'(ret_valid), 32'd0);
        cycle();
        rst = 1'b0;
        push_one(19'h00777);
        check("t6_post_top", 32'(top_addr), 32'h777);
        check("t6_post_count", 32'(count), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware return-address stack for the 19-bit CPU.
- Consumes the push / pop / ret strobes that the control unit decodes from call and return opcodes.
- Stores return PCs on push and hands back the top PC on pop/ret.
- Sits between the decode-stage control outputs and the fetch-stage PC mux; the hazard stall freezes it.

Parameters:
ADDR_W, 19, width of a stored PC / return address
DEPTH, 8, number of stack entries (power of two, >=2)
PTR_W, $clog2(DEPTH)+1, occupancy counter width (derived, localparam)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
push  input  1  push strobe from control (call)
pop  input  1  pop strobe from control (explicit pop)
ret  input  1  return strobe; acts as pop and requests redirect
hazard  input  1  pipeline stall; when 1 all strobes are ignored that cycle
push_addr  input  ADDR_W  return address to store (PC+1 from fetch)
clear_err  input  1  clears sticky error flags
top_addr  output  ADDR_W  current top entry, combinational; 0 when empty
ret_addr  output  ADDR_W  registered popped address
ret_valid  output  1  one-cycle pulse, ret_addr valid and redirect requested
count  output  PTR_W  current occupancy 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop/ret attempted while empty

Behaviour:
- Storage: DEPTH x ADDR_W register array, write pointer sp (index of next free slot), occupancy counter count.
- Reset (async, rst=1): sp=0, count=0, ret_addr=0, ret_valid=0, overflow=0, underflow=0. Array contents are don't-care but must not leak: top_addr=0 while empty.
- Effective strobes: do_push = push & ~hazard; do_pop = (pop | ret) & ~hazard. pop and ret in the same cycle count as one pop.
- do_push only, not full: mem[sp] <= push_addr, sp++, count++.
- do_pop only, not empty: ret_addr <= mem[sp-1], sp--, count--.
  - ret_valid <= 1 next cycle only if ret caused the pop; a pop-only does not pulse it.
  - Latency: 1 clock from the strobe edge to ret_addr/ret_valid.
- do_push and do_pop, not empty: replace the top entry.
  - ret_addr <= old top; mem[sp-1] <= push_addr; sp and count unchanged.
  - ret_valid follows the ret rule.
- do_push and do_pop, empty: treated as push only; underflow flag is set.
- Push while full (no pop): write dropped, state unchanged, overflow <= 1.
- Pop/ret while empty (no push): no state change, ret_addr held, ret_valid=0, underflow <= 1.
- Sticky flags: clear_err=1 clears both next edge. A same-cycle new error has priority, so the flag stays 1.
- ret_valid is a single-cycle pulse; it deasserts the following cycle unless a new ret pop occurs. Back-to-back rets give consecutive pulses with successive addresses.
- Pointer arithmetic is modulo DEPTH on sp; count saturates at 0 and DEPTH.
- Reset asserted mid-operation discards all entries immediately; no pulse is generated.

Optional Feature:
- Macro: CALL_STACK_WRAP_EN.
- Defined: push when full overwrites the oldest entry (circular).
  - sp advances modulo DEPTH; count stays DEPTH; overflow is still set.
  - Subsequent pops return the newest DEPTH entries.
- Undefined: the push is dropped as described above.

Decomposition:
- Shared cpu package: ADDR_W=19 constant, opcode constants for CALL/RET/PUSH/POP, stack-error encoding.
- Optional sub-module stack_regfile: DEPTH x ADDR_W array with one write port and one async read port. Pointer/count logic stays in call_stack.

Test Plan:
1. Reset then push 19'h00010, 19'h00020, 19'h00030 -> count=3, top_addr=19'h00030. Then ret x3 -> ret_addr 19'h00030, 19'h00020, 19'h00010 on consecutive ret_valid pulses; empty=1.
2. Push 8 addresses (DEPTH=8), then a 9th (19'h7FFFF) -> full=1, overflow=1, top_addr = 8th value. With CALL_STACK_WRAP_EN: top_addr=19'h7FFFF and the first entry is lost.
3. ret on empty -> ret_valid stays 0, underflow=1. Then clear_err -> underflow=0 next cycle.
4. Stack holds 19'h00100; push 19'h00200 and ret same cycle -> ret_addr=19'h00100, ret_valid=1, count=1, top_addr=19'h00200.
5. hazard=1 with push=1 and ret=1 -> no change to count, top_addr or flags; ret_valid=0.
6. Assert rst mid-sequence with count=5 -> count=0, empty=1, top_addr=0 and ret_valid=0 immediately, without a clock edge.
